fsb_term_ctrl: RTL
==================

// Module: fsb_term_ctrl
// PURPOSE
//  Parametrised 68000 front-side-bus cycle terminator for NCH chip-select channels.
//  Each channel has a per-channel minimum wait-state count and its own ready input.
//  Drives nDTACK for memory/IO cycles, nVPA for interrupt-acknowledge (autovector)
//  cycles, and nBERR on timeout or unmapped access. Sits between address decode and the CPU.
// PARAMETERS
//  NCH      4    number of chip-select channels (1..8)
//  WS_W     4    width of each per-channel wait-state field
//  TO_W     8    width of timeout counter
//  TIMEOUT  255  cycles from first nAS-low edge to nBERR (must be < 2**TO_W)
//  IACK_WS  1    minimum wait states for IACS (autovector) cycles
// PORTS
//  FCLK      in   1          CPU clock; all logic on posedge
//  RST       in   1          synchronous active-high reset
//  nAS       in   1          CPU address strobe, synchronous to FCLK
//  CS        in   NCH        channel selects, decoded from address
//  Ready     in   NCH        per-channel ready
//  WS        in   NCH*WS_W   per-channel min wait states; ch i = WS[i*WS_W +: WS_W]
//  QoSReady  in   1          global throttle; gates every DTACK/VPA termination
//  IACS      in   1          interrupt-acknowledge cycle select
//  TOEn      in   1          1 = enable timeout/nBERR generation
//  BACT      out  1          bus active: !nAS || nAS-low registered at previous edge
//  nDTACK    out  1          data transfer ack, registered, active low
//  nVPA      out  1          valid peripheral address (autovector), registered, active low
//  nBERR     out  1          bus error, registered, active low
//  ActCh     out  3          index of channel latched for current cycle
//  MultiHit  out  1          1-cycle pulse: >1 CS bit set at cycle start
//  TOPulse   out  1          1-cycle pulse coincident with nBERR assertion
// BEHAVIOUR
//  Reset: nDTACK=nVPA=nBERR=1, MultiHit=TOPulse=0, ActCh=0, counters 0, state HOLD.
//  States: IDLE, WAIT, TERM, HOLD.
//  k = first posedge in IDLE sampling nAS=0. At k: latch lowest-index set CS bit -> ActCh;
//   latch IACS; MultiHit=1 if popcount(CS)>1; load wait cnt (WS[ch], or IACK_WS if IACS).
//  Termination condition at edge t: (t-k) >= wait cnt && QoSReady && (IACS || Ready[ch]).
//   IACS cycles ignore CS/Ready. Condition is evaluated at k, so WS=0 with
//   Ready+QoSReady high at k gives termination at edge k.
//  Termination -> TERM: assert nVPA=0 if IACS, else nDTACK=0 (never both).
//  Unmapped: CS==0 and IACS=0 -> never terminates normally; only timeout ends it.
//  Timeout: if TOEn and not terminated by edge k+TIMEOUT -> nBERR=0, TOPulse=1, TERM.
//   TOEn=0: WAIT holds indefinitely. TOEn is sampled each cycle and is not latched at k.
//  Normal and timeout on the same edge: normal termination wins; nBERR stays 1.
//  TERM: outputs held until first edge sampling nAS=1; at that edge all negate -> IDLE.
//  Abort: nAS sampled 1 while in WAIT -> IDLE, no strobe, no error.
//  HOLD: entered from reset; wait for nAS=1 then IDLE. A cycle already in progress
//   when reset releases is never terminated by this block.
//  Wait counter saturates at 0. Timeout counter counts 0..TIMEOUT and never wraps.
//  nDTACK, nVPA and nBERR are mutually exclusive in every cycle.
// TESTING
//  WS[0]=0, CS=0001, Ready=1111, QoSReady=1, nAS low at edge 10 -> nDTACK=0 after edge 10,
//   nDTACK=1 after first edge with nAS=1.
//  WS[2]=3, CS=0100, Ready[2] rises at edge k+5 -> nDTACK low at k+5, not before.
//  WS[1]=0, CS=0010, Ready[1]=1, QoSReady low until k+4 -> nDTACK low at k+4.
//  IACS=1, IACK_WS=1 -> nVPA low at k+1, nDTACK stays 1; CS=0110 at k -> ActCh=1, MultiHit=1.
//  CS=0, TOEn=1, TIMEOUT=255 -> nBERR=0 and TOPulse=1 at k+255; TOEn=0 -> nBERR stays 1.
//  RST asserted during WAIT with nAS held low -> all strobes 1; no strobe until nAS high,
//   then a new cycle terminates normally; nAS high at k+2 with WS=5 -> abort, no strobe.

Source files
------------

// File: rtl/fsb_term_ctrl_if.sv
// fsb_term_ctrl_if: 68000 bus-termination signals between CPU/decode side and the terminator
interface fsb_term_ctrl_if #(
  parameter int NCH  = 4,
  parameter int WS_W = 4
);
  logic                nAS;
  logic [NCH-1:0]      CS;
  logic [NCH-1:0]      Ready;
  logic [NCH*WS_W-1:0] WS;
  logic                QoSReady;
  logic                IACS;
  logic                TOEn;
  logic                BACT;
  logic                nDTACK;
  logic                nVPA;
  logic                nBERR;
  logic [2:0]          ActCh;
  logic                MultiHit;
  logic                TOPulse;
  modport master (
    output nAS, CS, Ready, WS, QoSReady, IACS, TOEn,
    input  BACT, nDTACK, nVPA, nBERR, ActCh, MultiHit, TOPulse
  );
  modport slave (
    input  nAS, CS, Ready, WS, QoSReady, IACS, TOEn,
    output BACT, nDTACK, nVPA, nBERR, ActCh, MultiHit, TOPulse
  );
endinterface

// File: rtl/fsb_term_ctrl.sv
// fsb_term_ctrl: 68000 bus cycle terminator driving nDTACK/nVPA/nBERR per chip-select channel
module fsb_term_ctrl #(
  parameter int NCH     = 4,
  parameter int WS_W    = 4,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255,
  parameter int IACK_WS = 1
) (
  input logic           FCLK,
  input logic           RST,
  fsb_term_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, TERM, HOLD} state_t;
  state_t          state_q;
  logic [WS_W-1:0] wcnt_q;
  logic [TO_W-1:0] tcnt_q;
  logic [2:0]      ch_q;
  logic            iacs_q, mapped_q, nas_low_q;
  logic            ndtack_q, nvpa_q, nberr_q, mh_q, to_q;
  logic [2:0]      ch_d;
  logic [WS_W-1:0] ws_ch, ws_d;
  logic [3:0]      hits;
  logic            rdy_ch, rdy_act, norm_k, norm, tmo;
  // lowest-index selected channel wins; iterate downward so the last hit is the lowest
  always_comb begin
    ch_d    = '0;
    ws_ch   = '0;
    rdy_ch  = 1'b0;
    rdy_act = 1'b0;
    hits    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (bus.CS[i]) begin
        ch_d   = 3'(i);
        ws_ch  = bus.WS[i*WS_W +: WS_W];
        rdy_ch = bus.Ready[i];
      end
      if (ch_q == 3'(i)) rdy_act = bus.Ready[i];
      hits = hits + 4'(bus.CS[i]);
    end
  end
  assign ws_d     = bus.IACS ? WS_W'(IACK_WS) : ws_ch;
  assign norm_k   = ws_d == '0 && bus.QoSReady && (bus.IACS || (|bus.CS && rdy_ch));
  assign norm     = wcnt_q == '0 && bus.QoSReady && (iacs_q || (mapped_q && rdy_act));
  assign tmo      = bus.TOEn && tcnt_q >= TO_W'(TIMEOUT);
  assign bus.BACT     = !bus.nAS || nas_low_q;
  assign bus.nDTACK   = ndtack_q;
  assign bus.nVPA     = nvpa_q;
  assign bus.nBERR    = nberr_q;
  assign bus.ActCh    = ch_q;
  assign bus.MultiHit = mh_q;
  assign bus.TOPulse  = to_q;
  always_ff @(posedge FCLK) begin
    if (RST) begin
      state_q   <= HOLD;
      wcnt_q    <= '0;
      tcnt_q    <= '0;
      ch_q      <= '0;
      iacs_q    <= 1'b0;
      mapped_q  <= 1'b0;
      nas_low_q <= 1'b0;
      ndtack_q  <= 1'b1;
      nvpa_q    <= 1'b1;
      nberr_q   <= 1'b1;
      mh_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      nas_low_q <= !bus.nAS;
      mh_q      <= 1'b0;
      to_q      <= 1'b0;
      case (state_q)
        IDLE: if (!bus.nAS) begin
          ch_q     <= ch_d;
          iacs_q   <= bus.IACS;
          mapped_q <= |bus.CS;
          mh_q     <= hits > 4'd1;
          // counters hold the edge distance expected at the next edge
          wcnt_q   <= ws_d == '0 ? '0 : ws_d - 1'b1;
          tcnt_q   <= TIMEOUT == 0 ? '0 : TO_W'(1);
          if (norm_k) begin
            state_q  <= TERM;
            ndtack_q <= bus.IACS;
            nvpa_q   <= !bus.IACS;
          end else if (bus.TOEn && TIMEOUT == 0) begin
            state_q <= TERM;
            nberr_q <= 1'b0;
            to_q    <= 1'b1;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: if (bus.nAS) begin
          state_q <= IDLE;
        end else if (norm) begin
          state_q  <= TERM;
          ndtack_q <= iacs_q;
          nvpa_q   <= !iacs_q;
        end else if (tmo) begin
          state_q <= TERM;
          nberr_q <= 1'b0;
          to_q    <= 1'b1;
        end else begin
          wcnt_q <= wcnt_q == '0 ? '0 : wcnt_q - 1'b1;
          tcnt_q <= tcnt_q >= TO_W'(TIMEOUT) ? tcnt_q : tcnt_q + 1'b1;
        end
        TERM: if (bus.nAS) begin
          state_q  <= IDLE;
          ndtack_q <= 1'b1;
          nvpa_q   <= 1'b1;
          nberr_q  <= 1'b1;
        end
        default: state_q <= bus.nAS ? IDLE : HOLD;
      endcase
    end
  end
endmodule
